fixed_point_add_arbiter: RTL
============================

Name: fixed_point_add_arbiter

Overview:
- Shares one registered fixed-point adder between NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair on a valid/ready channel.
- The block grants at most one requester per cycle and performs the signed add with 1-cycle latency.
- The result returns on a single response channel, tagged with the requester ID and an overflow flag; the response channel supports backpressure.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- WIDTH, 8, operand/result width, signed two's complement.
- FRAC_BITS, 3, fractional bits (>0); binary point is identical on A, B and result, so no shifting is applied.
- ID_WIDTH, $clog2(NUM_REQ), width of the response tag.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- REQ_VALID  in  NUM_REQ  per-requester operand valid.
- REQ_READY  out  NUM_REQ  per-requester accept; one-hot or zero.
- REQ_A  in  NUM_REQ*WIDTH  packed operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- REQ_B  in  NUM_REQ*WIDTH  packed operand B, same packing as REQ_A.
- RSP_VALID  out  1  result valid.
- RSP_READY  in  1  downstream accepts result.
- RSP_ID  out  ID_WIDTH  index of the requester that produced the result.
- RSP_VALUE  out  WIDTH  A+B, wrapped to WIDTH.
- RSP_OVF  out  1  signed overflow occurred on this result.

Behaviour:
- Reset (RST=1 at a CLK edge):
  - RSP_VALID=0, RSP_ID=0, RSP_VALUE=0, RSP_OVF=0.
  - Priority pointer = 0.
  - REQ_READY=0 during the reset cycle.
  - Reset mid-operation discards any held result; no response is produced for it.
- Slot availability:
  - can_issue = !RSP_VALID || RSP_READY.
- Arbitration (combinational):
  - When can_issue, grant the first i with REQ_VALID[i]=1, searching from pointer upward with wrap: pointer, pointer+1, ..., NUM_REQ-1, 0, ..., pointer-1.
  - REQ_READY = one-hot grant, else all zero.
  - REQ_READY may depend on REQ_VALID and RSP_READY. REQ_VALID must not depend on REQ_READY.
- Requester rules:
  - Once REQ_VALID[i] is asserted, A/B must stay stable until the handshake.
  - Dropping VALID before the handshake is a protocol violation; behaviour in that case is unspecified.
- Pointer update:
  - On a handshake with requester g, pointer <= (g+1) mod NUM_REQ.
  - Otherwise the pointer holds.
- Issue (at the edge where the handshake occurs):
  - RSP_VALUE <= A_g + B_g (WIDTH-bit wrap, no saturation).
  - RSP_ID <= g.
  - RSP_OVF <= (A_g[MSB]==B_g[MSB]) && (sum[MSB]!=A_g[MSB]).
  - RSP_VALID <= 1.
- Drain:
  - If RSP_VALID && RSP_READY and no new issue: RSP_VALID <= 0.
  - Data registers hold their last value.
- Backpressure:
  - While RSP_VALID && !RSP_READY, all response outputs hold stable and REQ_READY=0.
- Latency and throughput:
  - Handshake at edge t → RSP_VALID=1 in the cycle following edge t.
  - Throughput is 1 result/cycle while RSP_READY=1.
- Simultaneous drain and issue:
  - The new result replaces the old one in the same edge; RSP_VALID stays 1 with no bubble.
- Idle:
  - No REQ_VALID → no grant; the pointer holds.
- Single active requester: granted every cycle regardless of pointer position.

Decomposition:
- Package fixed_point_pkg:
  - Shared WIDTH/FRAC_BITS defaults.
  - Helper function for signed-overflow detection.
  - ID width calculation.
- Sub-module rr_arbiter (parameter NUM_REQ):
  - Inputs: REQ vector, enable (can_issue), accept strobe.
  - Outputs: one-hot grant, encoded index.
  - Owns the pointer register.
- Top level owns the response register stage and the operand mux.

Test Plan:
- Reset mid-stream: RSP_VALID=1 held under RSP_READY=0, then RST pulsed → RSP_VALID=0 next cycle; after release, first grant goes to requester 0 even if requester 2 was next in order.
- Basic add (WIDTH=8, FRAC_BITS=3): req1 A=0x0C (1.5), B=0x12 (2.25), RSP_READY=1 → one cycle later RSP_VALID=1, RSP_ID=1, RSP_VALUE=0x1E (3.75), RSP_OVF=0.
- Fairness: all 4 REQ_VALID held high for 8 cycles, RSP_READY=1 → RSP_ID sequence 0,1,2,3,0,1,2,3 with no idle cycles.
- Overflow and wrap:
  - A=0x7F, B=0x01 → RSP_VALUE=0x80, RSP_OVF=1.
  - A=0x80, B=0xFF → RSP_VALUE=0x7F, RSP_OVF=1.
  - A=0xF8 (-1.0), B=0x08 (1.0) → RSP_VALUE=0x00, RSP_OVF=0.
- Backpressure: RSP_READY=0 for 5 cycles with req0 and req3 valid → REQ_READY=0 throughout and RSP_* stable. When RSP_READY rises, the next grant is issued in the same cycle and results continue with no bubble.
- Pointer wrap and idle: only req3 valid (grant, pointer→0), then 3 idle cycles, then req2 and req0 valid → req0 granted first, then req2.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Shared defaults and helpers for the fixed-point add arbiter.
package fixed_point_pkg;

    localparam int unsigned DEF_NUM_REQ   = 4;
    localparam int unsigned DEF_WIDTH     = 8;
    localparam int unsigned DEF_FRAC_BITS = 3;

    // Tag width for a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    // Two's complement add overflows when both operand signs agree and the sum sign differs.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a registered priority pointer.
module rr_arbiter
    import fixed_point_pkg::*;
#(
    parameter int unsigned NUM_REQ  = DEF_NUM_REQ,
    parameter int unsigned ID_WIDTH = id_width(NUM_REQ)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic                en_i,
    input  logic                accept_i,
    output logic [NUM_REQ-1:0]  gnt_c_o,
    output logic [ID_WIDTH-1:0] idx_c_o
);

    logic [ID_WIDTH-1:0] ptr_q;
    logic [ID_WIDTH-1:0] ptr_d;
    logic [ID_WIDTH-1:0] cand;
    logic                found;

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        gnt_c_o = '0;
        idx_c_o = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            cand = ID_WIDTH'((int'(ptr_q) + k) % int'(NUM_REQ));
            if (en_i && !found && req_i[cand]) begin
                found          = 1'b1;
                gnt_c_o[cand]  = 1'b1;
                idx_c_o        = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (accept_i) begin
            ptr_d = (idx_c_o == ID_WIDTH'(NUM_REQ - 1)) ? '0 : idx_c_o + ID_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fixed_point_add_arbiter.sv
// One registered signed fixed-point adder shared round-robin between NUM_REQ requesters.
module fixed_point_add_arbiter
    import fixed_point_pkg::*;
#(
    parameter int unsigned NUM_REQ   = DEF_NUM_REQ,
    parameter int unsigned WIDTH     = DEF_WIDTH,
    parameter int unsigned FRAC_BITS = DEF_FRAC_BITS,
    parameter int unsigned ID_WIDTH  = id_width(NUM_REQ)
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [NUM_REQ-1:0]         REQ_VALID,
    output logic [NUM_REQ-1:0]         REQ_READY,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_A,
    input  logic [NUM_REQ*WIDTH-1:0]   REQ_B,
    output logic                       RSP_VALID,
    input  logic                       RSP_READY,
    output logic [ID_WIDTH-1:0]        RSP_ID,
    output logic [WIDTH-1:0]           RSP_VALUE,
    output logic                       RSP_OVF
);

    logic                can_issue_c;
    logic                issue_c;
    logic [NUM_REQ-1:0]  gnt_c;
    logic [ID_WIDTH-1:0] gidx_c;
    logic [WIDTH-1:0]    a_sel_c;
    logic [WIDTH-1:0]    b_sel_c;
    logic [WIDTH-1:0]    sum_c;
    logic                ovf_c;

    logic                rsp_valid_q, rsp_valid_d;
    logic [ID_WIDTH-1:0] rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0]    rsp_value_q, rsp_value_d;
    logic                rsp_ovf_q,   rsp_ovf_d;

    // A, B and the sum share one binary point, so FRAC_BITS drives no datapath logic.
    logic frac_cfg_unused;
    assign frac_cfg_unused = (FRAC_BITS < WIDTH);

    // No grant while reset is asserted or while a held result is stalled.
    assign can_issue_c = (!rsp_valid_q || RSP_READY) && !RST;
    assign issue_c     = |gnt_c;
    assign REQ_READY   = gnt_c;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .clk_i    (CLK),
        .rst_i    (RST),
        .req_i    (REQ_VALID),
        .en_i     (can_issue_c),
        .accept_i (issue_c),
        .gnt_c_o  (gnt_c),
        .idx_c_o  (gidx_c)
    );

    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (gidx_c == ID_WIDTH'(i)) begin
                a_sel_c = REQ_A[i*WIDTH +: WIDTH];
                b_sel_c = REQ_B[i*WIDTH +: WIDTH];
            end
        end
        sum_c = a_sel_c + b_sel_c;
        ovf_c = add_ovf(a_sel_c[WIDTH-1], b_sel_c[WIDTH-1], sum_c[WIDTH-1]);
    end

    // A new issue overwrites the slot even when it drains on the same edge.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_value_d = rsp_value_q;
        rsp_ovf_d   = rsp_ovf_q;
        if (issue_c) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = gidx_c;
            rsp_value_d = sum_c;
            rsp_ovf_d   = ovf_c;
        end else if (rsp_valid_q && RSP_READY) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_value_q <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_value_q <= rsp_value_d;
            rsp_ovf_q   <= rsp_ovf_d;
        end
    end

    assign RSP_VALID = rsp_valid_q;
    assign RSP_ID    = rsp_id_q;
    assign RSP_VALUE = rsp_value_q;
    assign RSP_OVF   = rsp_ovf_q;

endmodule
